// File: rtl/uart_pkg.sv
// Shared UART definitions: FSM state encoding and bit-period helper.
// The StParity state is always part of the encoding so that uart_tx and uart_rx
// agree on it; it is only reached when UART_TX_PARITY_EN is defined.
package uart_pkg;

  typedef enum logic [2:0] {
    StIdle,
    StStart,
    StData,
    StParity,
    StStop
  } uart_state_e;

  // Integer clock cycles per line bit; the remainder is deliberately dropped.
  function automatic int unsigned cycles_per_bit(int unsigned clk_hz, int unsigned bit_rate);
    return clk_hz / bit_rate;
  endfunction

endpackage

// File: rtl/uart_bit_timer.sv
// Bit-period timer: counts enabled cycles and pulses bit_done_o on the last cycle
// of each CyclesPerBit-long period, then restarts from zero on its own.
// load_i restarts the period from the next cycle.
module uart_bit_timer #(
  parameter int unsigned CyclesPerBit = 434,
  parameter int unsigned CountW       = $clog2(CyclesPerBit + 1)
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic load_i,
  input  logic en_i,
  output logic bit_done_o
);

  logic [CountW-1:0] cnt_q, cnt_d;

  // Next count and end-of-period pulse.
  always_comb begin
    cnt_d      = cnt_q;
    bit_done_o = 1'b0;
    if (load_i) begin
      cnt_d = '0;
    end else if (en_i) begin
      if (cnt_q == CountW'(CyclesPerBit - 1)) begin
        bit_done_o = 1'b1;
        cnt_d      = '0;
      end else begin
        cnt_d = cnt_q + CountW'(1);
      end
    end
  end

  // Counter register.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/uart_tx.sv
// UART transmitter: start bit, PAYLOAD_BITS data bits LSB first, STOP_BITS stop bits.
// Optional feature: define UART_TX_PARITY_EN to send an even parity bit after the data.
// The line and busy flag are registered from next-state values so that both change
// exactly one cycle after the edge that accepts a request.
module uart_tx
  import uart_pkg::*;
#(
  parameter int unsigned BIT_RATE     = 115200,
  parameter int unsigned CLK_HZ       = 50000000,
  parameter int unsigned PAYLOAD_BITS = 8,
  parameter int unsigned STOP_BITS    = 1
) (
  input  logic                    clk,
  input  logic                    resetn,
  output logic                    uart_txd,
  output logic                    uart_tx_busy,
  input  logic                    uart_tx_en,
  input  logic [PAYLOAD_BITS-1:0] uart_tx_data
);

  localparam int unsigned CyclesPerBit = cycles_per_bit(CLK_HZ, BIT_RATE);
  localparam int unsigned CountW       = $clog2(CyclesPerBit + 1);
  localparam int unsigned IdxW         = $clog2(PAYLOAD_BITS + 1);

  uart_state_e             state_q, state_d;
  logic [PAYLOAD_BITS-1:0] shift_q, shift_d;
  logic [IdxW-1:0]         idx_q, idx_d;
  logic                    txd_q, txd_d;
  logic                    busy_q, busy_d;
  logic                    timer_load;
  logic                    bit_done;
`ifdef UART_TX_PARITY_EN
  logic                    parity_q, parity_d;
`endif

  uart_bit_timer #(
    .CyclesPerBit(CyclesPerBit),
    .CountW      (CountW)
  ) u_bit_timer (
    .clk_i     (clk),
    .rst_ni    (resetn),
    .load_i    (timer_load),
    .en_i      (state_q != StIdle),
    .bit_done_o(bit_done)
  );

  // Frame sequencing; idx_q counts data bits, then is reused for stop bits.
  always_comb begin
    state_d    = state_q;
    shift_d    = shift_q;
    idx_d      = idx_q;
    txd_d      = txd_q;
    timer_load = 1'b0;
`ifdef UART_TX_PARITY_EN
    parity_d   = parity_q;
`endif
    unique case (state_q)
      StIdle: begin
        // busy_q is low whenever state_q is StIdle, so this is the accept qualifier.
        if (uart_tx_en) begin
          state_d    = StStart;
          shift_d    = uart_tx_data;
          idx_d      = '0;
          txd_d      = 1'b0;
          timer_load = 1'b1;
`ifdef UART_TX_PARITY_EN
          parity_d   = ^uart_tx_data;
`endif
        end
      end
      StStart: begin
        if (bit_done) begin
          state_d = StData;
          txd_d   = shift_q[0];
        end
      end
      StData: begin
        if (bit_done) begin
          if (idx_q == IdxW'(PAYLOAD_BITS - 1)) begin
            idx_d = '0;
`ifdef UART_TX_PARITY_EN
            state_d = StParity;
            txd_d   = parity_q;
`else
            state_d = StStop;
            txd_d   = 1'b1;
`endif
          end else begin
            idx_d   = idx_q + IdxW'(1);
            shift_d = shift_q >> 1;
            txd_d   = shift_d[0];
          end
        end
      end
`ifdef UART_TX_PARITY_EN
      StParity: begin
        if (bit_done) begin
          state_d = StStop;
          txd_d   = 1'b1;
        end
      end
`endif
      StStop: begin
        if (bit_done) begin
          if (idx_q == IdxW'(STOP_BITS - 1)) begin
            state_d = StIdle;
            idx_d   = '0;
          end else begin
            idx_d = idx_q + IdxW'(1);
          end
          txd_d = 1'b1;
        end
      end
      default: begin
        state_d = StIdle;
        txd_d   = 1'b1;
      end
    endcase
    busy_d = (state_d != StIdle);
  end

  // State, datapath and registered line outputs.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q  <= StIdle;
      shift_q  <= '0;
      idx_q    <= '0;
      txd_q    <= 1'b1;
      busy_q   <= 1'b0;
`ifdef UART_TX_PARITY_EN
      parity_q <= 1'b0;
`endif
    end else begin
      state_q  <= state_d;
      shift_q  <= shift_d;
      idx_q    <= idx_d;
      txd_q    <= txd_d;
      busy_q   <= busy_d;
`ifdef UART_TX_PARITY_EN
      parity_q <= parity_d;
`endif
    end
  end

  assign uart_txd     = txd_q;
  assign uart_tx_busy = busy_q;

endmodule

// File: doc/uart_tx.md
UART_TX -- requirements
Module: uart_tx

Interface
REQ-001 SHALL have parameter BIT_RATE, default 115200, line bit rate in bits/s.
REQ-002 SHALL have parameter CLK_HZ, default 50000000, system clock frequency in Hz.
REQ-003 SHALL have parameter PAYLOAD_BITS, default 8, data bits per frame.
REQ-004 SHALL have parameter STOP_BITS, default 1, stop bits per frame (legal values 1 or 2).
REQ-005 SHALL have port clk  input  1  single system clock; all logic is on its rising edge.
REQ-006 SHALL have port resetn  input  1  asynchronous, active-low reset.
REQ-007 SHALL have port uart_txd  output  1  UART transmit line; idle high.
REQ-008 SHALL have port uart_tx_busy  output  1  high while a frame is in progress.
REQ-009 SHALL have port uart_tx_en  input  1  send request, qualified by uart_tx_busy low.
REQ-010 SHALL have port uart_tx_data  input  PAYLOAD_BITS  byte to send.

Function
REQ-011 SHALL compute CYCLES_PER_BIT = CLK_HZ / BIT_RATE (integer division; 434 at the defaults) and size the bit counter to $clog2(CYCLES_PER_BIT+1).
REQ-012 SHALL implement FSM states IDLE, START, DATA, STOP; transitions: IDLE->START on accepted request; START->DATA after CYCLES_PER_BIT cycles; DATA->STOP after PAYLOAD_BITS bit periods; STOP->IDLE after STOP_BITS bit periods.
REQ-013 SHALL accept a request on the rising edge where uart_tx_en=1 and uart_tx_busy=0, and capture uart_tx_data into an internal shift register on that same edge.
REQ-014 SHALL drive uart_txd low (start bit) and uart_tx_busy high from the cycle after acceptance: one-cycle latency.
REQ-015 SHALL hold each line bit for exactly CYCLES_PER_BIT cycles; data bits are sent LSB first; stop bits are driven high.
REQ-016 SHALL keep uart_tx_busy high for exactly (1+PAYLOAD_BITS+STOP_BITS)*CYCLES_PER_BIT cycles per frame, and lower it in the same cycle the FSM returns to IDLE.
REQ-017 SHALL ignore uart_tx_en and uart_tx_data changes while busy, with no queuing and no corruption of the frame in flight.
REQ-018 SHALL accept a request in the first cycle busy is low, so back-to-back frames have no idle gap beyond the stop bits.
REQ-019 SHALL register uart_txd so that it is glitch-free.

Reset
REQ-020 SHALL, while resetn is low, asynchronously force uart_txd=1, uart_tx_busy=0, FSM=IDLE, and clear the counters and shift register.
REQ-021 SHALL, on reset asserted mid-frame, abandon the frame with the line high immediately; after release, no partial frame resumes and the next request starts a full frame.

Configuration
REQ-022 SHALL, when UART_TX_PARITY_EN is defined, insert a PARITY state between DATA and STOP that transmits even parity (XOR of payload bits) for one bit period, and extend the busy time by CYCLES_PER_BIT.
REQ-023 SHALL, when UART_TX_PARITY_EN is undefined, contain no parity logic, with frame timing per REQ-016.

Structure
REQ-024 SHALL take the FSM state typedef (including PARITY) and a cycles-per-bit helper function from shared package uart_pkg, which uart_rx also uses.
REQ-025 SHALL place bit-period timing in sub-module uart_bit_timer (load/count, pulses bit_done after CYCLES_PER_BIT cycles); the FSM, shift register and bit index stay in uart_tx.

Verification
REQ-026 SHALL cover: after reset, send 0x55 -> uart_txd reads 0,1,0,1,0,1,0,1,0,1, each bit held 434 cycles; busy high for 4340 cycles.
REQ-027 SHALL cover: pulse uart_tx_en with 0xA3 while busy sending 0x0F -> line carries 0x0F only; 0xA3 is never sent.
REQ-028 SHALL cover: hold uart_tx_en high with 0x00 then 0xFF -> two frames back to back; the start bit of the second immediately follows the stop bit of the first.
REQ-029 SHALL cover: assert resetn low during data bit 3 -> uart_txd=1 and busy=0 within the reset cycle; after release, sending 0x81 yields a clean full frame.
REQ-030 SHALL cover: loopback of uart_txd into uart_rx with 10 $random bytes -> every uart_rx_data on uart_rx_valid matches, with 10 passes and 0 fails.
REQ-031 SHALL cover, with UART_TX_PARITY_EN defined: send 0x07 -> parity bit 1, busy for 11*434 cycles; send 0x03 -> parity bit 0.
